// File: rtl/elevator_request_ctrl.sv
// Request/dispatch stage for the elevator car: latches floor calls, tracks the
// current floor and travel direction, and tells the car FSM when to move.
module elevator_request_ctrl #(
  parameter int NUM_FLOORS = 4,
  parameter int FLR_W      = 2
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NUM_FLOORS-1:0] CallBtn,
  input  logic                  DoorOpen,
  input  logic                  clr,
  input  logic                  flrChg,
  output logic                  Moving,
  output logic [FLR_W-1:0]      CurFlr,
  output logic                  Dir,
  output logic [NUM_FLOORS-1:0] Pending
);

  localparam logic [FLR_W-1:0] TOP_FLR = FLR_W'(NUM_FLOORS - 1);

  logic [NUM_FLOORS-1:0] req, req_nxt;
  logic                  cur_req, up_req, dn_req;
  logic                  dir_nxt;
  logic [FLR_W-1:0]      flr_nxt;

  // Split the request vector around the current floor.
  always_comb begin
    cur_req = 1'b0;
    up_req  = 1'b0;
    dn_req  = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (i == 32'(CurFlr))      cur_req = req[i];
      else if (i > 32'(CurFlr))  up_req  = up_req | req[i];
      else                       dn_req  = dn_req | req[i];
    end
  end

  assign Moving  = (up_req | dn_req) & ~cur_req;
  assign Pending = req;

  // Clearing at the open door takes priority over a simultaneous press.
  always_comb begin
    req_nxt = req | CallBtn;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (DoorOpen && (i == 32'(CurFlr))) req_nxt[i] = 1'b0;
    end
  end

  always_comb begin
    dir_nxt = Dir;
    if (clr) begin
      if (Dir) dir_nxt = up_req ? 1'b1 : (dn_req ? 1'b0 : 1'b1);
      else     dir_nxt = dn_req ? 1'b0 : (up_req ? 1'b1 : 1'b0);
    end
  end

  // Floor step uses the pre-update direction and saturates at both ends.
  always_comb begin
    flr_nxt = CurFlr;
    if (flrChg) begin
      if (Dir && (CurFlr != TOP_FLR))      flr_nxt = CurFlr + FLR_W'(1);
      else if (!Dir && (CurFlr != '0))     flr_nxt = CurFlr - FLR_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      req    <= '0;
      CurFlr <= '0;
      Dir    <= 1'b1;
    end else begin
      req    <= req_nxt;
      CurFlr <= flr_nxt;
      Dir    <= dir_nxt;
    end
  end

endmodule
